// File: rtl/ps_feeder_pkg.sv
// Shared definitions for the line feeder: 3-bit state encoding and counter sizing helper.
package ps_feeder_pkg;

   localparam logic [2:0] PS_ST_IDLE       = 3'd0;
   localparam logic [2:0] PS_ST_WAIT_REQ   = 3'd1;
   localparam logic [2:0] PS_ST_BURST      = 3'd2;
   localparam logic [2:0] PS_ST_FLUSH_WAIT = 3'd3;
   localparam logic [2:0] PS_ST_FLUSH      = 3'd4;
   localparam logic [2:0] PS_ST_DONE       = 3'd5;

   // One spare bit so a counter can always hold its own terminal count.
   function automatic int unsigned PS_PIX_W(input int unsigned n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/ps_line_feeder.sv
// Frame sequencer: answers line requests with exact one-line bursts, aligns to SOF,
// appends zero flush lines and pulses frame-done.
module ps_line_feeder
   import ps_feeder_pkg::*;
#(
   parameter int unsigned LINE_LENGTH = 640,
   parameter int unsigned LINE_COUNT  = 480,
   parameter int unsigned DATA_WIDTH  = 1,
   parameter int unsigned FLUSH_LINES = 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_valid,
   input  logic                  i_sof,
   output logic                  o_ready,
   input  logic                  i_req,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_valid,
   output logic                  o_busy,
   output logic                  o_frame_done,
   output logic                  o_sof_err,
   output logic                  o_drop
);

   localparam int unsigned PixW   = PS_PIX_W(LINE_LENGTH);
   localparam int unsigned LineW  = PS_PIX_W(LINE_COUNT);
   localparam int unsigned FlushW = PS_PIX_W(FLUSH_LINES + 1);

   localparam logic [PixW-1:0]   PixLast   = PixW'(LINE_LENGTH - 1);
   localparam logic [LineW-1:0]  LineLast  = LineW'(LINE_COUNT - 1);
   localparam logic [FlushW-1:0] FlushLast = FlushW'((FLUSH_LINES == 0) ? 0 : FLUSH_LINES - 1);

   typedef enum logic [2:0] {
      StIdle      = PS_ST_IDLE,
      StWaitReq   = PS_ST_WAIT_REQ,
      StBurst     = PS_ST_BURST,
      StFlushWait = PS_ST_FLUSH_WAIT,
      StFlush     = PS_ST_FLUSH,
      StDone      = PS_ST_DONE
   } state_e;

   state_e                state_q, state_d;
   logic [PixW-1:0]       pix_q, pix_d;
   logic [LineW-1:0]      line_q, line_d;
   logic [FlushW-1:0]     flush_q, flush_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  valid_q, valid_d;
   logic                  done_q;
   logic                  sof_err_q, sof_err_d;
   logic                  drop_q, drop_d;
   logic                  ready;
   logic                  take;

   always_comb begin
      state_d   = state_q;
      pix_d     = pix_q;
      line_d    = line_q;
      flush_d   = flush_q;
      data_d    = '0;
      valid_d   = 1'b0;
      sof_err_d = 1'b0;
      drop_d    = 1'b0;
      ready     = 1'b0;
      take      = 1'b0;

      unique case (state_q)
         StIdle: begin
            ready = i_req;
            if (i_valid && i_req) begin
               if (i_sof) take = 1'b1;
               else       drop_d = 1'b1;
            end
         end
         StWaitReq: begin
            if (i_req) state_d = StBurst;
         end
         StBurst: begin
            ready = 1'b1;
            if (i_valid) begin
               take      = 1'b1;
               sof_err_d = i_sof && ((pix_q != '0) || (line_q != '0));
            end
         end
         StFlushWait: begin
            if (i_req) state_d = StFlush;
         end
         StFlush: begin
            valid_d = 1'b1;
            if (pix_q == PixLast) begin
               pix_d = '0;
               if (flush_q == FlushLast) begin
                  flush_d = '0;
                  state_d = StDone;
               end else begin
                  flush_d = flush_q + 1'b1;
                  state_d = StFlushWait;
               end
            end else begin
               pix_d = pix_q + 1'b1;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Counters are zero in idle, so the SOF pixel shares the burst path as pixel 0 of line 0.
      if (take) begin
         data_d  = i_data;
         valid_d = 1'b1;
         if (pix_q == PixLast) begin
            pix_d = '0;
            if (line_q == LineLast) begin
               line_d  = '0;
               state_d = (FLUSH_LINES == 0) ? StDone : StFlushWait;
            end else begin
               line_d  = line_q + 1'b1;
               state_d = StWaitReq;
            end
         end else begin
            pix_d   = pix_q + 1'b1;
            state_d = StBurst;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= StIdle;
         pix_q     <= '0;
         line_q    <= '0;
         flush_q   <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         done_q    <= 1'b0;
         sof_err_q <= 1'b0;
         drop_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pix_q     <= pix_d;
         line_q    <= line_d;
         flush_q   <= flush_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         done_q    <= (state_q == StDone);
         sof_err_q <= sof_err_d;
         drop_q    <= drop_d;
      end
   end

   assign o_ready      = ready;
   assign o_data       = data_q;
   assign o_valid      = valid_q;
   assign o_busy       = (state_q != StIdle);
   assign o_frame_done = done_q;
   assign o_sof_err    = sof_err_q;
   assign o_drop       = drop_q;

endmodule

// File: tb/tb_ps_line_feeder.sv
// Bench for ps_line_feeder: table and random frames against a queue model of the frame,
// plus reset mid-line and a zero-flush-line instance.
module tb_ps_line_feeder;

   localparam int LL        = 4;
   localparam int LC        = 3;
   localparam int FL        = 1;
   localparam int DW        = 8;
   localparam int FRAME_PIX = LL * LC;

   typedef struct {
      int    garbage;
      int    stray;
      int    p_valid;  // <0: valid toggles 1010
      int    p_req;    // <0: req pulses once every 4 cycles
      int    base;     // <0: random data, else base+1..base+12
      int    exp_drops;
      int    exp_errs;
      string name;
   } row_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] a_data, b_data, a_odata, b_odata;
   logic          a_valid, a_sof, a_req, b_valid, b_sof, b_req;
   logic          a_ready, b_ready, a_ovalid, b_ovalid, a_busy, b_busy;
   logic          a_done, b_done, a_err, b_err, a_drop, b_drop;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   logic [DW-1:0] a_got[$];
   logic [DW-1:0] b_got[$];
   int a_drops, a_errs, a_dones, a_done_cyc, a_last_valid, b_dones, b_done_cyc, b_last_valid;
   logic a_busy_at_done;

   always #5 clk = ~clk;

   ps_line_feeder #(
      .LINE_LENGTH(LL), .LINE_COUNT(LC), .DATA_WIDTH(DW), .FLUSH_LINES(FL)
   ) u_dut_a (
      .i_clk(clk), .i_rst(rst), .i_data(a_data), .i_valid(a_valid), .i_sof(a_sof),
      .o_ready(a_ready), .i_req(a_req), .o_data(a_odata), .o_valid(a_ovalid),
      .o_busy(a_busy), .o_frame_done(a_done), .o_sof_err(a_err), .o_drop(a_drop)
   );

   ps_line_feeder #(
      .LINE_LENGTH(LL), .LINE_COUNT(LC), .DATA_WIDTH(DW), .FLUSH_LINES(0)
   ) u_dut_b (
      .i_clk(clk), .i_rst(rst), .i_data(b_data), .i_valid(b_valid), .i_sof(b_sof),
      .o_ready(b_ready), .i_req(b_req), .o_data(b_odata), .o_valid(b_ovalid),
      .o_busy(b_busy), .o_frame_done(b_done), .o_sof_err(b_err), .o_drop(b_drop)
   );

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   task automatic clear_mon();
      a_got.delete();
      b_got.delete();
      a_drops = 0; a_errs = 0; a_dones = 0; a_done_cyc = -1; a_last_valid = -100;
      b_dones = 0; b_done_cyc = -1; b_last_valid = -100;
      a_busy_at_done = 1'bx;
   endtask

   // Advance one clock and record what both DUTs present after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (a_ovalid) begin a_got.push_back(a_odata); a_last_valid = cyc; end
      if (a_drop) a_drops++;
      if (a_err)  a_errs++;
      if (a_done) begin a_dones++; a_done_cyc = cyc; a_busy_at_done = a_busy; end
      if (b_ovalid) begin b_got.push_back(b_odata); b_last_valid = cyc; end
      if (b_done) begin b_dones++; b_done_cyc = cyc; end
   endtask

   task automatic run_frame(input row_t r);
      logic [DW-1:0] pq[$];
      logic [DW-1:0] exp_q[$];
      bit            sq[$];
      logic [DW-1:0] v;
      int            n_acc, k;
      bit            bubble;
      for (int g = 0; g < r.garbage; g++) begin
         pq.push_back(DW'($urandom));
         sq.push_back(1'b0);
      end
      for (int i = 0; i < FRAME_PIX; i++) begin
         v = (r.base < 0) ? DW'($urandom) : DW'(r.base + i + 1);
         pq.push_back(v);
         sq.push_back(i == 0 || i == r.stray);
         exp_q.push_back(v);
      end
      for (int i = 0; i < LL * FL; i++) exp_q.push_back('0);
      clear_mon();
      n_acc  = 0;
      k      = 0;
      bubble = 1'b0;
      while (a_dones == 0 && k < 3000) begin
         a_valid = (pq.size() > 0) &&
                   ((r.p_valid < 0) ? (k % 2 == 0) : ($urandom_range(99) < r.p_valid));
         a_data  = (pq.size() > 0) ? pq[0] : '0;
         a_sof   = (pq.size() > 0) ? sq[0] : 1'b0;
         a_req   = (r.p_req < 0) ? (k % 4 == 0) : ($urandom_range(99) < r.p_req);
         #1;
         if (bubble) check({r.name, " bubble"}, 64'(a_ready), 64'(0));
         bubble = 1'b0;
         if (a_valid && a_ready) begin
            void'(pq.pop_front());
            void'(sq.pop_front());
            n_acc++;
            if (n_acc > r.garbage && ((n_acc - r.garbage) % LL) == 0) bubble = 1'b1;
         end
         tick();
         k++;
      end
      a_valid = 1'b0; a_sof = 1'b0; a_req = 1'b0;
      repeat (3) tick();
      check({r.name, " accepted"}, 64'(n_acc), 64'(r.garbage + FRAME_PIX));
      check({r.name, " out_len"}, 64'(a_got.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
         check({r.name, " pix"}, (i < a_got.size()) ? 64'(a_got[i]) : 64'hx, 64'(exp_q[i]));
      check({r.name, " drops"}, 64'(a_drops), 64'(r.exp_drops));
      check({r.name, " sof_err"}, 64'(a_errs), 64'(r.exp_errs));
      check({r.name, " done_cnt"}, 64'(a_dones), 64'(1));
      check({r.name, " done_time"}, 64'(a_done_cyc), 64'(a_last_valid + 1));
      check({r.name, " busy_at_done"}, 64'(a_busy_at_done), 64'(0));
   endtask

   initial begin
      row_t rows[5];
      row_t rr;
      int   n, k;

      rows[0] = '{0, -1, 100, 100, 0,   0, 0, "nominal"};
      rows[1] = '{3, -1, 100, 100, 20,  3, 0, "pre_sof"};
      rows[2] = '{0, -1, -1,  -1,  40,  0, 0, "gaps_reqdrop"};
      rows[3] = '{0, 6,  100, 100, 60,  0, 1, "stray_sof"};
      rows[4] = '{2, 6,  60,  50,  80,  2, 1, "mixed"};

      rst = 1'b1;
      a_data = '0; a_valid = 1'b0; a_sof = 1'b0; a_req = 1'b0;
      b_data = '0; b_valid = 1'b0; b_sof = 1'b0; b_req = 1'b0;
      clear_mon();
      repeat (3) tick();
      rst = 1'b0;
      #1;
      check("rst o_valid", 64'(a_ovalid), 64'(0));
      check("rst o_data", 64'(a_odata), 64'(0));
      check("rst o_busy", 64'(a_busy), 64'(0));
      check("rst o_ready", 64'(a_ready), 64'(0));
      check("rst o_frame_done", 64'(a_done), 64'(0));
      check("rst o_drop", 64'(a_drop + a_err), 64'(0));

      for (int i = 0; i < 5; i++) run_frame(rows[i]);

      for (int i = 0; i < 8; i++) begin
         rr.garbage   = $urandom_range(3);
         rr.stray     = ($urandom_range(1) == 1) ? int'($urandom_range(FRAME_PIX - 1, 1)) : -1;
         rr.p_valid   = $urandom_range(100, 30);
         rr.p_req     = $urandom_range(100, 20);
         rr.base      = -1;
         rr.exp_drops = rr.garbage;
         rr.exp_errs  = (rr.stray >= 0) ? 1 : 0;
         rr.name      = "random";
         run_frame(rr);
      end

      // Reset while pixel 2 of line 1 is being offered.
      clear_mon();
      a_req = 1'b1;
      n = 0;
      k = 0;
      while (n < LL + 2 && k < 100) begin
         a_valid = 1'b1;
         a_data  = DW'(n + 1);
         a_sof   = (n == 0);
         #1;
         if (a_valid && a_ready) n++;
         tick();
         k++;
      end
      check("midline busy", 64'(a_busy), 64'(1));
      rst    = 1'b1;
      a_data = DW'(n + 1);
      a_sof  = 1'b0;
      tick();
      rst     = 1'b0;
      a_valid = 1'b0;
      a_req   = 1'b0;
      #1;
      check("midrst o_valid", 64'(a_ovalid), 64'(0));
      check("midrst o_data", 64'(a_odata), 64'(0));
      check("midrst o_busy", 64'(a_busy), 64'(0));
      check("midrst pulses", 64'({a_done, a_err, a_drop}), 64'(0));
      check("midrst ready_noreq", 64'(a_ready), 64'(0));
      a_req = 1'b1;
      #1;
      check("midrst ready_idle", 64'(a_ready), 64'(1));
      a_req = 1'b0;
      rows[0].name = "after_reset";
      run_frame(rows[0]);

      // Zero flush lines: frame-done follows the last real pixel directly.
      clear_mon();
      b_req = 1'b1;
      n = 0;
      k = 0;
      while (b_dones == 0 && k < 300) begin
         b_valid = (n < FRAME_PIX);
         b_data  = DW'(n + 1);
         b_sof   = (n == 0);
         #1;
         if (b_valid && b_ready) n++;
         tick();
         k++;
      end
      b_valid = 1'b0; b_req = 1'b0; b_sof = 1'b0;
      repeat (3) tick();
      check("noflush out_len", 64'(b_got.size()), 64'(FRAME_PIX));
      for (int i = 0; i < FRAME_PIX; i++)
         check("noflush pix", (i < b_got.size()) ? 64'(b_got[i]) : 64'hx, 64'(i + 1));
      check("noflush done_cnt", 64'(b_dones), 64'(1));
      check("noflush done_time", 64'(b_done_cyc), 64'(b_last_valid + 1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ps_line_feeder.md
# ps_line_feeder

Frame sequencer between the upstream pixel FIFO and the kernel line-buffer controller (`ps_kernel_control`). It answers the controller's level request with exact one-line bursts of `LINE_LENGTH` pixels and aligns each frame to the upstream start-of-frame flag. After the last real line it injects `FLUSH_LINES` zero lines, so the controller's last-row padding path runs and the filter pipeline drains. It then pulses frame-done.

## Interface
Parameters:
- `LINE_LENGTH`, default 640: pixels per line.
- `LINE_COUNT`, default 480: real lines per frame.
- `DATA_WIDTH`, default 1: pixel width.
- `FLUSH_LINES`, default 1: zero lines appended per frame; 0 is legal.

Ports:
- `i_clk`, in, 1: the only clock.
- `i_rst`, in, 1: reset; synchronous, active-high.
- `i_data`, in, `DATA_WIDTH`: upstream pixel.
- `i_valid`, in, 1: upstream pixel valid.
- `i_sof`, in, 1: marks the first pixel of a frame; qualified by `i_valid`.
- `o_ready`, out, 1: upstream accept. A pixel transfers when `i_valid && o_ready`.
- `i_req`, in, 1: line request from the kernel controller (its `o_req`).
- `o_data`, out, `DATA_WIDTH`: pixel to the kernel controller.
- `o_valid`, out, 1: pixel valid to the kernel controller.
- `o_busy`, out, 1: high in every state except IDLE.
- `o_frame_done`, out, 1: one-cycle pulse at frame end.
- `o_sof_err`, out, 1: one-cycle pulse when `i_sof` is seen on a pixel that is not pixel 0 of the frame.
- `o_drop`, out, 1: one-cycle pulse for each pre-SOF pixel discarded.

## Operation
- States: IDLE, WAIT_REQ, BURST, FLUSH_WAIT, FLUSH, DONE.
- IDLE:
  - `o_ready = i_req`.
  - Accepted pixel with `i_sof=0`: discard it and pulse `o_drop`.
  - Accepted pixel with `i_sof=1`: forward it as pixel 0 of line 0; pix_cnt=1; go to BURST.
- WAIT_REQ:
  - `o_ready=0`.
  - On `i_req=1`, go to BURST.
- BURST:
  - `o_ready=1`. Every accepted pixel is forwarded and increments pix_cnt.
  - Upstream gaps are allowed; pix_cnt holds while `i_valid=0`.
  - `i_req` is sampled only on entry; a drop mid-burst is ignored.
  - On acceptance of pixel `LINE_LENGTH-1`: pix_cnt becomes 0 and line_cnt increments.
    - If line_cnt was `LINE_COUNT-1`: line_cnt becomes 0; go to FLUSH_WAIT, or to DONE if `FLUSH_LINES=0`.
    - Otherwise go to WAIT_REQ.
  - An accepted pixel with `i_sof=1` and pix_cnt or line_cnt nonzero pulses `o_sof_err`. It is still forwarded as a normal pixel; there is no resynchronisation.
- FLUSH_WAIT:
  - `o_ready=0`.
  - On `i_req=1`, go to FLUSH.
- FLUSH:
  - `o_ready=0`. Emit one zero pixel every cycle, `LINE_LENGTH` consecutive cycles.
  - Each flush line requires a fresh `i_req`, sampled in FLUSH_WAIT.
  - After `FLUSH_LINES` lines, go to DONE.
- DONE:
  - One cycle only; pulse `o_frame_done`; go to IDLE.
  - The next frame again requires `i_sof`.
- Counter widths:
  - pix_cnt: `$clog2(LINE_LENGTH)+1` bits.
  - line_cnt: `$clog2(LINE_COUNT)+1` bits.
  - flush_cnt: `$clog2(FLUSH_LINES+1)+1` bits.
  - All counters compare for equality; none wraps unchecked.
- Reset at any point, mid-frame included:
  - state IDLE, all counters 0.
  - `o_data=0`, and `o_valid`, `o_busy`, `o_frame_done`, `o_sof_err`, `o_drop` all 0.
  - A partially delivered line is abandoned. The kernel controller must be reset in the same cycle; this is the integrator's responsibility.

## Timing
- `o_data`/`o_valid` are registered: 1-cycle latency from the acceptance edge, or from the flush-emit cycle.
- `o_ready` is decoded from registered state only, never combinationally from `i_valid`. Exception: in IDLE, `o_ready` is gated by `i_req`.
- After the final accepted pixel of a line, `o_ready` is 0 on the next cycle. Exactly `LINE_LENGTH` pixels transfer per burst.
- Back-to-back lines: BURST → WAIT_REQ → BURST costs at least 1 bubble cycle when `i_req` is held high.
- `o_frame_done` is high one cycle after the `o_valid` cycle of the last flush pixel, or of the last real pixel when `FLUSH_LINES=0`.
- Pulses `o_sof_err` and `o_drop` are registered and aligned with the `o_valid` slot of the offending pixel.
- `o_busy` is 0 in the cycle after DONE.

## Structure
- Shared package `ps_feeder_pkg`: state encoding localparams (3-bit) and a `PS_PIX_W` helper function for counter widths. `ps_kernel_control` integration reuses the same line-geometry parameters.
- Single flat module. No sub-module: the counters and FSM are small enough to sit together.

## Test plan
Bench parameters: `LINE_LENGTH=4`, `LINE_COUNT=3`, `FLUSH_LINES=1`.
- Nominal frame: `i_sof` on pixel 0, `i_req` held high, continuous `i_valid`, data 1..12 → `o_valid` carries 12 pixels in order, then 4 zeros. `o_frame_done` is high exactly once, one cycle after the last zero. `o_ready` asserts for exactly 12 acceptances.
- Pre-SOF garbage: 3 pixels with `i_sof=0`, then SOF → 3 `o_drop` pulses, no `o_valid` for them, and the frame otherwise matches the nominal case.
- Gaps and request drop: `i_valid` toggles 1010 and `i_req` falls mid-burst → the burst still completes 4 pixels. The next burst waits for `i_req`; no pixel is lost or duplicated.
- Stray SOF: `i_sof=1` on pixel 6 → one `o_sof_err` pulse. That pixel is forwarded and frame totals are unchanged.
- Reset mid-line at pixel 2 of line 1 → all outputs 0 on the next cycle and state IDLE. A new SOF frame then delivers the nominal sequence.
- `FLUSH_LINES=0` variant → no zero pixels; `o_frame_done` one cycle after pixel 12.
